// File: rtl/ccff_chain_loader.sv
// Drives a configuration-flop chain: serialises bitstream words into it (LOAD)
// or flushes, injects a single token and measures the chain length (TEST).
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 36,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = $clog2(2*CHAIN_LEN+1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    output logic              test_fail,
    output logic [CNT_W-1:0]  len_meas
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] TWO_LEN_C = CNT_W'(2 * CHAIN_LEN);
    localparam logic [IDX_W-1:0] IDX_MSB_C = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE_C = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_INJECT,
        S_MEASURE,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q,  word_d;
    logic               full_q,  full_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               head_q,  head_d;
    logic               fail_q,  fail_d;
    logic [CNT_W-1:0]   len_q,   len_d;

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            full_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            head_q  <= 1'b0;
            fail_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            full_q  <= full_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            fail_q  <= fail_d;
            len_q   <= len_d;
        end
    end

    // cnt_q is shared: bits shifted in LOAD, flush cycles in FLUSH, meas_cnt in MEASURE.
    always_comb begin
        logic accept;
        state_d = state_q;
        word_d  = word_q;
        full_d  = full_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        fail_d  = fail_q;
        len_d   = len_q;
        accept  = bs_valid && bs_ready;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    full_d = 1'b0;
                    head_d = 1'b0;
                    if (mode) begin
                        state_d = S_FLUSH;
                        fail_d  = 1'b0;
                        len_d   = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (full_q) begin
                    head_d = word_q[idx_q];
                    cnt_d  = cnt_q + ONE_C;
                    if (cnt_q == LAST_C) begin
                        state_d = S_FIN;
                        full_d  = 1'b0;
                    end else if (idx_q == '0) begin
                        // Refill on the last bit so consecutive words shift without a bubble.
                        full_d = accept;
                        if (accept) begin
                            word_d = bs_data;
                            idx_d  = IDX_MSB_C;
                        end
                    end else begin
                        idx_d = idx_q - IDX_ONE_C;
                    end
                end else if (accept) begin
                    word_d = bs_data;
                    full_d = 1'b1;
                    idx_d  = IDX_MSB_C;
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q + ONE_C;
                if (cnt_q == LAST_C) begin
                    state_d = S_INJECT;
                end
            end
            S_INJECT: begin
                cnt_d   = ONE_C;
                state_d = S_MEASURE;
            end
            S_MEASURE: begin
                if (ccff_tail) begin
                    len_d   = cnt_q;
                    fail_d  = (cnt_q != LEN_C);
                    state_d = S_FIN;
                end else if (cnt_q == TWO_LEN_C) begin
                    len_d   = '0;
                    fail_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bs_ready     = 1'b0;
        ccff_head    = 1'b0;
        chain_clk_en = 1'b0;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        test_fail    = fail_q;
        len_meas     = len_q;

        unique case (state_q)
            S_LOAD: begin
                chain_clk_en = full_q;
                ccff_head    = full_q ? word_q[idx_q] : head_q;
                bs_ready     = !full_q || ((idx_q == '0) && (cnt_q != LAST_C));
            end
            S_FLUSH: begin
                chain_clk_en = 1'b1;
            end
            S_INJECT: begin
                chain_clk_en = 1'b1;
                ccff_head    = 1'b1;
            end
            S_MEASURE: begin
                chain_clk_en = 1'b1;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
